// File: rtl/radio_seq_pkg.sv
// Shared types and reset defaults for the radio enable/RX sequencer.
package radio_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RX     = 2'd2,
        COOL   = 2'd3
    } seq_state_e;

    localparam int WARMUP_DEF = 16;
    localparam int RXWIN_DEF  = 256;
    localparam int COOL_DEF   = 4;
    localparam int STATS_W    = 16;

endpackage

// File: rtl/radio_seq_timer.sv
// Loadable down-counter shared by all sequencer phases; stops at zero instead of wrapping.
module radio_seq_timer #(
    parameter int W = 16
) (
    input  logic         ck,
    input  logic         arst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge ck) begin
        if (arst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/radio_seq_ctrl.sv
// Radio warm-up / RX window / cool-down sequencer with isolation abort.
// Optional done/abort statistics counters are built when RADIO_SEQ_STATS_EN is defined.
module radio_seq_ctrl #(
    parameter int CNT_W      = 16,
    parameter int WARMUP_DEF = radio_seq_pkg::WARMUP_DEF,
    parameter int RXWIN_DEF  = radio_seq_pkg::RXWIN_DEF,
    parameter int COOL_DEF   = radio_seq_pkg::COOL_DEF
) (
    input  logic                               ck,
    input  logic                               arst,
    input  logic                               isolateM1,
    input  logic                               cfgWe,
    input  logic [CNT_W-1:0]                   cfgWarmup,
    input  logic [CNT_W-1:0]                   cfgRxWin,
    input  logic [CNT_W-1:0]                   cfgCool,
    input  logic                               startReq,
    output logic                               startAck,
    input  logic                               stopReq,
    output logic                               radioEnableSynced,
    output logic                               radioRxEnSynced,
    output logic                               busy,
    output logic [1:0]                         seqState,
    output logic                               done,
    output logic                               abort,
    output logic [radio_seq_pkg::STATS_W-1:0]  cntDone,
    output logic [radio_seq_pkg::STATS_W-1:0]  cntAbort
);

    import radio_seq_pkg::*;

    seq_state_e       state;
    seq_state_e       nextState;
    logic [CNT_W-1:0] cfgWarmupQ;
    logic [CNT_W-1:0] cfgRxWinQ;
    logic [CNT_W-1:0] cfgCoolQ;
    logic             tmrLoad;
    logic             tmrDec;
    logic [CNT_W-1:0] tmrValue;
    logic             tmrZero;
    logic             enterCool;
    logic             ackNext;
    logic             doneNext;
    logic             abortNext;

    radio_seq_timer #(.W(CNT_W)) uTimer (
        .ck    (ck),
        .arst  (arst),
        .load  (tmrLoad),
        .value (tmrValue),
        .dec   (tmrDec),
        .zero  (tmrZero)
    );

    // Isolation outranks everything; a zero cool-down skips COOL and completes directly.
    always_comb begin
        nextState = state;
        tmrLoad   = 1'b0;
        tmrDec    = 1'b0;
        tmrValue  = '0;
        enterCool = 1'b0;
        ackNext   = 1'b0;
        doneNext  = 1'b0;
        abortNext = 1'b0;
        if ((state != IDLE) && isolateM1) begin
            nextState = IDLE;
            abortNext = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (startReq && !isolateM1) begin
                        nextState = WARMUP;
                        ackNext   = 1'b1;
                        tmrLoad   = 1'b1;
                        tmrValue  = (cfgWarmupQ == '0) ? '0 : cfgWarmupQ - CNT_W'(1);
                    end
                end
                WARMUP: begin
                    if (stopReq) begin
                        enterCool = 1'b1;
                    end else if (tmrZero) begin
                        nextState = RX;
                        if (cfgRxWinQ != '0) begin
                            tmrLoad  = 1'b1;
                            tmrValue = cfgRxWinQ - CNT_W'(1);
                        end
                    end else begin
                        tmrDec = 1'b1;
                    end
                end
                RX: begin
                    if (stopReq || (tmrZero && (cfgRxWinQ != '0))) begin
                        enterCool = 1'b1;
                    end else begin
                        tmrDec = 1'b1;
                    end
                end
                COOL: begin
                    if (tmrZero) begin
                        nextState = IDLE;
                        doneNext  = 1'b1;
                    end else begin
                        tmrDec = 1'b1;
                    end
                end
                default: nextState = IDLE;
            endcase
            if (enterCool) begin
                if (cfgCoolQ == '0) begin
                    nextState = IDLE;
                    doneNext  = 1'b1;
                end else begin
                    nextState = COOL;
                    tmrLoad   = 1'b1;
                    tmrValue  = cfgCoolQ - CNT_W'(1);
                end
            end
        end
    end

    // Enables are flopped from the next state so they change on the same edge as the state.
    always_ff @(posedge ck) begin
        if (arst) begin
            state             <= IDLE;
            cfgWarmupQ        <= CNT_W'(WARMUP_DEF);
            cfgRxWinQ         <= CNT_W'(RXWIN_DEF);
            cfgCoolQ          <= CNT_W'(COOL_DEF);
            startAck          <= 1'b0;
            done              <= 1'b0;
            abort             <= 1'b0;
            radioEnableSynced <= 1'b0;
            radioRxEnSynced   <= 1'b0;
        end else begin
            state             <= nextState;
            startAck          <= ackNext;
            done              <= doneNext;
            abort             <= abortNext;
            radioEnableSynced <= (nextState != IDLE);
            radioRxEnSynced   <= (nextState == RX);
            if ((state == IDLE) && cfgWe) begin
                cfgWarmupQ <= cfgWarmup;
                cfgRxWinQ  <= cfgRxWin;
                cfgCoolQ   <= cfgCool;
            end
        end
    end

    assign busy     = (state != IDLE);
    assign seqState = state;

`ifdef RADIO_SEQ_STATS_EN
    logic [STATS_W-1:0] doneCnt;
    logic [STATS_W-1:0] abortCnt;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge ck) begin
        if (arst) begin
            doneCnt  <= '0;
            abortCnt <= '0;
        end else begin
            if (done && (doneCnt != '1)) begin
                doneCnt <= doneCnt + STATS_W'(1);
            end
            if (abort && (abortCnt != '1)) begin
                abortCnt <= abortCnt + STATS_W'(1);
            end
        end
    end

    assign cntDone  = doneCnt;
    assign cntAbort = abortCnt;
`else
    assign cntDone  = '0;
    assign cntAbort = '0;
`endif

endmodule

// File: tb/tb_radio_seq_ctrl.sv
// Directed testbench for radio_seq_ctrl; expected cycle patterns are derived from W/R/C by hand.
module tb_radio_seq_ctrl;

    logic        ck = 1'b0;
    logic        arst = 1'b1;
    logic        isolateM1 = 1'b0;
    logic        cfgWe = 1'b0;
    logic [15:0] cfgWarmup = '0;
    logic [15:0] cfgRxWin = '0;
    logic [15:0] cfgCool = '0;
    logic        startReq = 1'b0;
    logic        stopReq = 1'b0;
    logic        startAck;
    logic        radioEnableSynced;
    logic        radioRxEnSynced;
    logic        busy;
    logic [1:0]  seqState;
    logic        done;
    logic        abort;
    logic [15:0] cntDone;
    logic [15:0] cntAbort;

    int checks = 0;
    int errors = 0;

    radio_seq_ctrl dut (
        .ck                (ck),
        .arst              (arst),
        .isolateM1         (isolateM1),
        .cfgWe             (cfgWe),
        .cfgWarmup         (cfgWarmup),
        .cfgRxWin          (cfgRxWin),
        .cfgCool           (cfgCool),
        .startReq          (startReq),
        .startAck          (startAck),
        .stopReq           (stopReq),
        .radioEnableSynced (radioEnableSynced),
        .radioRxEnSynced   (radioRxEnSynced),
        .busy              (busy),
        .seqState          (seqState),
        .done              (done),
        .abort             (abort),
        .cntDone           (cntDone),
        .cntAbort          (cntAbort)
    );

    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic loadCfg(input int w, input int r, input int c);
        cfgWarmup = 16'(w);
        cfgRxWin  = 16'(r);
        cfgCool   = 16'(c);
        cfgWe     = 1'b1;
        tick();
        cfgWe     = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        tick();
        tick();
        arst = 1'b0;
        checks++; if (radioEnableSynced !== 1'b0) begin errors++; $display("[TB] FAIL reset.en: got %b expected 0", radioEnableSynced); end
        checks++; if (radioRxEnSynced !== 1'b0) begin errors++; $display("[TB] FAIL reset.rx: got %b expected 0", radioRxEnSynced); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset.busy: got %b expected 0", busy); end
        checks++; if (seqState !== 2'd0) begin errors++; $display("[TB] FAIL reset.state: got %0d expected 0", seqState); end
        checks++; if (startAck !== 1'b0) begin errors++; $display("[TB] FAIL reset.ack: got %b expected 0", startAck); end
        checks++; if (done !== 1'b0 || abort !== 1'b0) begin errors++; $display("[TB] FAIL reset.pulses: got done=%b abort=%b expected 0/0", done, abort); end
        checks++; if (cntDone !== 16'd0 || cntAbort !== 16'd0) begin errors++; $display("[TB] FAIL reset.counters: got %0d/%0d expected 0/0", cntDone, cntAbort); end
    endtask

    task automatic test_reset_mid();
        loadCfg(10, 2, 2);
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        tick();
        tick();
        checks++; if (seqState !== 2'd1 || radioEnableSynced !== 1'b1) begin errors++; $display("[TB] FAIL resetmid.pre: got state=%0d en=%b expected 1/1", seqState, radioEnableSynced); end
        arst = 1'b1;
        tick();
        arst = 1'b0;
        checks++; if (radioEnableSynced !== 1'b0 || radioRxEnSynced !== 1'b0) begin errors++; $display("[TB] FAIL resetmid.en: got en=%b rx=%b expected 0/0", radioEnableSynced, radioRxEnSynced); end
        checks++; if (seqState !== 2'd0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL resetmid.state: got state=%0d busy=%b expected 0/0", seqState, busy); end
        // Defaults are W=16, R=256, C=4 regardless of the 10/2/2 still on the config inputs.
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        for (int k = 1; k <= 277; k++) begin
            checks++; if (radioEnableSynced !== (k <= 276)) begin errors++; $display("[TB] FAIL resetmid.en cycle %0d: got %b expected %b", k, radioEnableSynced, (k <= 276)); end
            checks++; if (radioRxEnSynced !== (k >= 17 && k <= 272)) begin errors++; $display("[TB] FAIL resetmid.rx cycle %0d: got %b expected %b", k, radioRxEnSynced, (k >= 17 && k <= 272)); end
            checks++; if (done !== (k == 277)) begin errors++; $display("[TB] FAIL resetmid.done cycle %0d: got %b expected %b", k, done, (k == 277)); end
            tick();
        end
    endtask

    task automatic test_basic();
        loadCfg(3, 5, 2);
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        checks++; if (startAck !== 1'b1 || seqState !== 2'd1) begin errors++; $display("[TB] FAIL basic.ack: got ack=%b state=%0d expected 1/1", startAck, seqState); end
        for (int k = 1; k <= 12; k++) begin
            checks++; if (radioEnableSynced !== (k <= 10)) begin errors++; $display("[TB] FAIL basic.en cycle %0d: got %b expected %b", k, radioEnableSynced, (k <= 10)); end
            checks++; if (radioRxEnSynced !== (k >= 4 && k <= 8)) begin errors++; $display("[TB] FAIL basic.rx cycle %0d: got %b expected %b", k, radioRxEnSynced, (k >= 4 && k <= 8)); end
            checks++; if (done !== (k == 11)) begin errors++; $display("[TB] FAIL basic.done cycle %0d: got %b expected %b", k, done, (k == 11)); end
            checks++; if (busy !== (k <= 10)) begin errors++; $display("[TB] FAIL basic.busy cycle %0d: got %b expected %b", k, busy, (k <= 10)); end
            if (k > 1) begin
                checks++; if (startAck !== 1'b0) begin errors++; $display("[TB] FAIL basic.ackpulse cycle %0d: got %b expected 0", k, startAck); end
            end
            tick();
        end
    endtask

    task automatic test_stop_r0();
        loadCfg(2, 0, 3);
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            checks++; if (radioEnableSynced !== (k <= 25)) begin errors++; $display("[TB] FAIL stop.en cycle %0d: got %b expected %b", k, radioEnableSynced, (k <= 25)); end
            checks++; if (radioRxEnSynced !== (k >= 3 && k <= 22)) begin errors++; $display("[TB] FAIL stop.rx cycle %0d: got %b expected %b", k, radioRxEnSynced, (k >= 3 && k <= 22)); end
            checks++; if (done !== (k == 26)) begin errors++; $display("[TB] FAIL stop.done cycle %0d: got %b expected %b", k, done, (k == 26)); end
            stopReq = (k == 22);
            tick();
        end
        stopReq = 1'b0;
    endtask

    task automatic test_isolate();
        startReq = 1'b1;
        tick();
        startReq = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checks++; if (radioRxEnSynced !== (k >= 3)) begin errors++; $display("[TB] FAIL iso.rx cycle %0d: got %b expected %b", k, radioRxEnSynced, (k >= 3)); end
            isolateM1 = (k == 4);
            tick();
        end
        startReq = 1'b1;
        checks++; if (radioEnableSynced !== 1'b0 || radioRxEnSynced !== 1'b0) begin errors++; $display("[TB] FAIL iso.en: got en=%b rx=%b expected 0/0", radioEnableSynced, radioRxEnSynced); end
        checks++; if (abort !== 1'b1) begin errors++; $display("[TB] FAIL iso.abort: got %b expected 1", abort); end
        checks++; if (seqState !== 2'd0) begin errors++; $display("[TB] FAIL iso.state: got %0d expected 0", seqState); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL iso.nodone: got %b expected 0", done); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (startAck !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL iso.ignore step %0d: got ack=%b busy=%b expected 0/0", k, startAck, busy); end
            checks++; if (abort !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL iso.pulses step %0d: got abort=%b done=%b expected 0/0", k, abort, done); end
        end
        startReq  = 1'b0;
        isolateM1 = 1'b0;
        tick();
    endtask

    task automatic test_stats();
`ifdef RADIO_SEQ_STATS_EN
        checks++; if (cntDone !== 16'd3) begin errors++; $display("[TB] FAIL stats.done: got %0d expected 3", cntDone); end
        checks++; if (cntAbort !== 16'd1) begin errors++; $display("[TB] FAIL stats.abort: got %0d expected 1", cntAbort); end
`else
        checks++; if (cntDone !== 16'd0) begin errors++; $display("[TB] FAIL stats.done: got %0d expected 0", cntDone); end
        checks++; if (cntAbort !== 16'd0) begin errors++; $display("[TB] FAIL stats.abort: got %0d expected 0", cntAbort); end
`endif
    endtask

    task automatic test_cfg_lock();
        int expW[3] = '{2, 2, 1};
        int expR[3] = '{3, 3, 2};
        int expC[3] = '{1, 1, 1};
        int total;
        loadCfg(2, 3, 1);
        cfgWarmup = 16'd5;
        cfgRxWin  = 16'd7;
        cfgCool   = 16'd4;
        for (int s = 0; s < 3; s++) begin
            if (s == 2) loadCfg(1, 2, 1);
            total = expW[s] + expR[s] + expC[s];
            startReq = 1'b1;
            tick();
            startReq = 1'b0;
            for (int k = 1; k <= total + 1; k++) begin
                checks++; if (radioEnableSynced !== (k <= total)) begin errors++; $display("[TB] FAIL cfg%0d.en cycle %0d: got %b expected %b", s, k, radioEnableSynced, (k <= total)); end
                checks++; if (radioRxEnSynced !== (k > expW[s] && k <= expW[s] + expR[s])) begin errors++; $display("[TB] FAIL cfg%0d.rx cycle %0d: got %b expected %b", s, k, radioRxEnSynced, (k > expW[s] && k <= expW[s] + expR[s])); end
                checks++; if (done !== (k == total + 1)) begin errors++; $display("[TB] FAIL cfg%0d.done cycle %0d: got %b expected %b", s, k, done, (k == total + 1)); end
                cfgWe = (s == 0 && k == 1);
                tick();
            end
            cfgWe = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] expEnV   = 9'b001110111;
        logic [8:0] expRxV   = 9'b001100110;
        logic [8:0] expAckV  = 9'b000010001;
        logic [8:0] expDoneV = 9'b010001000;
        loadCfg(0, 2, 0);
        startReq = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) begin
            checks++; if (radioEnableSynced !== expEnV[k-1]) begin errors++; $display("[TB] FAIL b2b.en cycle %0d: got %b expected %b", k, radioEnableSynced, expEnV[k-1]); end
            checks++; if (radioRxEnSynced !== expRxV[k-1]) begin errors++; $display("[TB] FAIL b2b.rx cycle %0d: got %b expected %b", k, radioRxEnSynced, expRxV[k-1]); end
            checks++; if (startAck !== expAckV[k-1]) begin errors++; $display("[TB] FAIL b2b.ack cycle %0d: got %b expected %b", k, startAck, expAckV[k-1]); end
            checks++; if (done !== expDoneV[k-1]) begin errors++; $display("[TB] FAIL b2b.done cycle %0d: got %b expected %b", k, done, expDoneV[k-1]); end
            if (k == 5) startReq = 1'b0;
            tick();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b.idle: got busy=%b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_basic();
        test_stop_r0();
        test_isolate();
        test_stats();
        test_cfg_lock();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
